// File: rtl/tetris_board_if.sv
// Lock handshake between the game controller (master) and the playfield (slave).
// Coordinates pack four cells: column i at cx[4i+3:4i], row i at cy[5i+4:5i].
interface tetris_board_if;
   logic        lock_valid;
   logic        lock_ready;
   logic [2:0]  lock_type;
   logic [15:0] lock_cx;
   logic [19:0] lock_cy;

   modport master (
      output lock_valid, lock_type, lock_cx, lock_cy,
      input  lock_ready
   );

   modport slave (
      input  lock_valid, lock_type, lock_cx, lock_cy,
      output lock_ready
   );
endinterface

// File: rtl/tetris_board.sv
// Playfield grid owner: writes locked pieces, removes full rows one row per cycle,
// and answers combinational collision queries for the falling piece.
module tetris_board #(
   parameter int ROWS = 20,
   parameter int COLS = 10
) (
   input  logic                Clk,
   input  logic                Reset_n,
   input  logic                clear_board,
   tetris_board_if.slave       lock,
   input  logic [15:0]         q_cx,
   input  logic [19:0]         q_cy,
   output logic                q_hit,
   output logic [2:0]          grid [ROWS][COLS],
   output logic                lock_done,
   output logic [2:0]          lines_cleared,
   output logic [15:0]         lines_total,
   output logic                top_out
);

   localparam int RW = $clog2(ROWS);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_SCAN, S_DONE} state_t;

   state_t         state, state_nx;
   logic           ready;
   logic           accept;
   logic           row_full;
   logic [RW-1:0]  row_ptr;
   logic [2:0]     cap_type;
   logic [15:0]    cap_cx;
   logic [19:0]    cap_cy;

   assign lock.lock_ready = ready;

   always_ff @(posedge Clk) begin
      if (!Reset_n) state <= S_IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      ready     = 1'b0;
      accept    = 1'b0;
      lock_done = 1'b0;
      case (state)
         S_IDLE: begin
            ready  = !clear_board && Reset_n;
            accept = lock.lock_valid && ready;
            if (accept) state_nx = S_WRITE;
         end
         S_WRITE: state_nx = S_SCAN;
         S_SCAN:  if (!row_full && row_ptr == '0) state_nx = S_DONE;
         S_DONE: begin
            lock_done = 1'b1;
            state_nx  = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      row_full = 1'b1;
      for (int unsigned c = 0; c < COLS; c++)
         if (grid[row_ptr][c] == 3'd0) row_full = 1'b0;
   end

   always_comb begin
      q_hit = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (q_cx[4*i +: 4] >= 4'(COLS) || q_cy[5*i +: 5] >= 5'(ROWS))
            q_hit = 1'b1;
         else if (grid[q_cy[5*i +: 5]][q_cx[4*i +: 4]] != 3'd0)
            q_hit = 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         for (int unsigned r = 0; r < ROWS; r++)
            for (int unsigned c = 0; c < COLS; c++)
               grid[r][c] <= '0;
         row_ptr       <= '0;
         cap_type      <= '0;
         cap_cx        <= '0;
         cap_cy        <= '0;
         lines_cleared <= '0;
         lines_total   <= '0;
         top_out       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (clear_board) begin
                  for (int unsigned r = 0; r < ROWS; r++)
                     for (int unsigned c = 0; c < COLS; c++)
                        grid[r][c] <= '0;
                  top_out <= 1'b0;
               end else if (accept) begin
                  cap_type      <= lock.lock_type;
                  cap_cx        <= lock.lock_cx;
                  cap_cy        <= lock.lock_cy;
                  lines_cleared <= '0;
               end
            end
            S_WRITE: begin
               // Occupancy is judged on the pre-lock grid, so duplicate cells never flag each other.
               for (int unsigned i = 0; i < 4; i++) begin
                  if (cap_cx[4*i +: 4] >= 4'(COLS) || cap_cy[5*i +: 5] >= 5'(ROWS)) begin
                     top_out <= 1'b1;
                  end else begin
                     if (grid[cap_cy[5*i +: 5]][cap_cx[4*i +: 4]] != 3'd0) top_out <= 1'b1;
                     grid[cap_cy[5*i +: 5]][cap_cx[4*i +: 4]] <= cap_type;
                  end
               end
               row_ptr <= RW'(ROWS - 1);
            end
            S_SCAN: begin
               if (row_full) begin
                  // Pointer stays put so the row shifted in gets rechecked next cycle.
                  for (int unsigned j = 1; j < ROWS; j++)
                     if (j <= 32'(row_ptr)) grid[j] <= grid[j-1];
                  for (int unsigned c = 0; c < COLS; c++)
                     grid[0][c] <= '0;
                  if (lines_cleared != 3'd7)  lines_cleared <= lines_cleared + 3'd1;
                  if (lines_total != 16'hFFFF) lines_total  <= lines_total + 16'd1;
               end else if (row_ptr != '0) begin
                  row_ptr <= row_ptr - RW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tetris_board.sv
// Randomised bench for tetris_board: a whole-lock reference model (write, then compact
// away full rows) checked every idle cycle, plus directed scenarios with literal values.
module tb_tetris_board;

   logic        clk;
   logic        rst_n;
   logic        clear_board;
   logic [15:0] q_cx;
   logic [19:0] q_cy;
   logic        q_hit;
   logic [2:0]  grid [20][10];
   logic        lock_done;
   logic [2:0]  lines_cleared;
   logic [15:0] lines_total;
   logic        top_out;

   tetris_board_if lk();

   tetris_board #(.ROWS(20), .COLS(10)) dut (
      .Clk           (clk),
      .Reset_n       (rst_n),
      .clear_board   (clear_board),
      .lock          (lk),
      .q_cx          (q_cx),
      .q_cy          (q_cy),
      .q_hit         (q_hit),
      .grid          (grid),
      .lock_done     (lock_done),
      .lines_cleared (lines_cleared),
      .lines_total   (lines_total),
      .top_out       (top_out)
   );

   int m_grid [20][10];
   int m_top, m_total, m_cleared, m_cnt;
   bit chk_en;
   bit q_rand_en;
   int n_checks;
   int n_fail;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [15:0] pcx(input int a, input int b, input int c, input int d);
      return {4'(d), 4'(c), 4'(b), 4'(a)};
   endfunction

   function automatic logic [19:0] pcy(input int a, input int b, input int c, input int d);
      return {5'(d), 5'(c), 5'(b), 5'(a)};
   endfunction

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a lock is resolved in one go; the DUT needs 22+k cycles to show it.
   task automatic model_zero();
      for (int r = 0; r < 20; r++)
         for (int c = 0; c < 10; c++)
            m_grid[r][c] = 0;
   endtask

   task automatic model_lock(input int t, input logic [15:0] cx, input logic [19:0] cy);
      int pre [20][10];
      int tmp [20][10];
      int x, y, w, k;
      bit full;
      pre = m_grid;
      for (int i = 0; i < 4; i++) begin
         x = int'(cx[4*i +: 4]);
         y = int'(cy[5*i +: 5]);
         if (x >= 10 || y >= 20) m_top = 1;
         else begin
            if (pre[y][x] != 0) m_top = 1;
            m_grid[y][x] = t;
         end
      end
      for (int r = 0; r < 20; r++)
         for (int c = 0; c < 10; c++)
            tmp[r][c] = 0;
      w = 19;
      k = 0;
      for (int r = 19; r >= 0; r--) begin
         full = 1;
         for (int c = 0; c < 10; c++)
            if (m_grid[r][c] == 0) full = 0;
         if (full) k++;
         else begin
            for (int c = 0; c < 10; c++) tmp[w][c] = m_grid[r][c];
            w--;
         end
      end
      m_grid    = tmp;
      m_cleared = (k > 7) ? 7 : k;
      m_total   = (m_total + k > 65535) ? 65535 : m_total + k;
      m_cnt     = 22 + k;
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         model_zero();
         m_top = 0; m_total = 0; m_cleared = 0; m_cnt = 0;
      end else if (m_cnt > 0) begin
         m_cnt--;
      end else if (clear_board) begin
         model_zero();
         m_top = 0;
      end else if (lk.lock_valid) begin
         model_lock(int'(lk.lock_type), lk.lock_cx, lk.lock_cy);
      end
   end

   function automatic int model_qhit();
      int x, y;
      for (int i = 0; i < 4; i++) begin
         x = int'(q_cx[4*i +: 4]);
         y = int'(q_cy[5*i +: 5]);
         if (x >= 10 || y >= 20) return 1;
         if (m_grid[y][x] != 0) return 1;
      end
      return 0;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         int mism, fr, fc;
         check("lock_ready", int'(lk.lock_ready), (m_cnt == 0 && !clear_board && rst_n) ? 1 : 0);
         check("lock_done", int'(lock_done), (m_cnt == 1) ? 1 : 0);
         if (m_cnt == 0) begin
            mism = 0; fr = 0; fc = 0;
            for (int r = 0; r < 20; r++)
               for (int c = 0; c < 10; c++)
                  if (int'(grid[r][c]) != m_grid[r][c]) begin
                     if (mism == 0) begin fr = r; fc = c; end
                     mism++;
                  end
            n_checks++;
            if (mism != 0) begin
               n_fail++;
               $display("FAIL grid: %0d cells differ, first [%0d][%0d] got %0d expected %0d at %0t",
                        mism, fr, fc, grid[fr][fc], m_grid[fr][fc], $time);
            end
            check("top_out", int'(top_out), m_top);
            check("lines_total", int'(lines_total), m_total);
            check("lines_cleared", int'(lines_cleared), m_cleared);
            check("q_hit", int'(q_hit), model_qhit());
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q_rand_en) begin
            for (int i = 0; i < 4; i++) begin
               q_cx[4*i +: 4] = 4'($urandom_range(0, 10));
               q_cy[5*i +: 5] = 5'($urandom_range(0, 20));
            end
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge clk);
      while (!lk.lock_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("ready_timeout", 0, 1);
   endtask

   task automatic do_lock(input int t, input logic [15:0] cx, input logic [19:0] cy, output int done_cyc);
      wait_ready();
      @(posedge clk); #1;
      lk.lock_valid = 1'b1;
      lk.lock_type  = 3'(t);
      lk.lock_cx    = cx;
      lk.lock_cy    = cy;
      @(posedge clk); #1;
      lk.lock_valid = 1'b0;
      done_cyc = 0;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         if (lock_done) begin
            done_cyc = n;
            break;
         end
      end
   endtask

   task automatic do_clear();
      wait_ready();
      @(posedge clk); #1 clear_board = 1'b1;
      @(posedge clk); #1 clear_board = 1'b0;
   endtask

   task automatic no_done_window(input string nm);
      int seen;
      seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (lock_done) seen = 1;
      end
      check(nm, seen, 0);
   endtask

   initial begin
      int d;
      logic [15:0] cx;
      logic [19:0] cy;
      int x0, y0;

      n_checks = 0; n_fail = 0; chk_en = 0; q_rand_en = 0;
      rst_n = 1'b0; clear_board = 1'b0;
      lk.lock_valid = 1'b0; lk.lock_type = '0; lk.lock_cx = '0; lk.lock_cy = '0;
      q_cx = pcx(0, 1, 2, 3); q_cy = pcy(0, 0, 0, 0);

      @(posedge clk); #1 chk_en = 1;
      @(negedge clk);
      check("ready_in_reset", int'(lk.lock_ready), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", int'(lk.lock_ready), 1);
      check("qhit_after_reset", int'(q_hit), 0);
      check("total_after_reset", int'(lines_total), 0);

      // O piece on the floor
      do_lock(4, pcx(4, 5, 4, 5), pcy(18, 18, 19, 19), d);
      check("o_done_cycle", d, 22);
      check("o_cell_18_4", int'(grid[18][4]), 4);
      check("o_cell_19_5", int'(grid[19][5]), 4);
      check("o_cleared", int'(lines_cleared), 0);
      check("o_top_out", int'(top_out), 0);

      // Rows 18-19 filled except column 0, then a vertical I clears both
      do_lock(3, pcx(1, 2, 3, 6), pcy(18, 18, 18, 18), d);
      do_lock(3, pcx(7, 8, 9, 9), pcy(18, 18, 18, 18), d);
      do_lock(3, pcx(1, 2, 3, 6), pcy(19, 19, 19, 19), d);
      do_lock(3, pcx(7, 8, 9, 9), pcy(19, 19, 19, 19), d);
      do_lock(1, pcx(0, 0, 0, 0), pcy(16, 17, 18, 19), d);
      check("i_done_cycle", d, 24);
      check("i_cleared", int'(lines_cleared), 2);
      check("i_total", int'(lines_total), 2);
      check("i_cell_19_0", int'(grid[19][0]), 1);
      check("i_cell_18_0", int'(grid[18][0]), 1);
      check("i_cell_19_4", int'(grid[19][4]), 0);
      check("i_cell_0_0", int'(grid[0][0]), 0);
      check("i_cell_1_0", int'(grid[1][0]), 0);

      // Full rows 17 and 19 around a partial row 18
      do_clear();
      do_lock(3, pcx(1, 2, 3, 4), pcy(19, 19, 19, 19), d);
      do_lock(3, pcx(5, 6, 7, 8), pcy(19, 19, 19, 19), d);
      do_lock(3, pcx(9, 1, 2, 3), pcy(19, 17, 17, 17), d);
      do_lock(3, pcx(4, 5, 6, 7), pcy(17, 17, 17, 17), d);
      do_lock(5, pcx(8, 9, 3, 3), pcy(17, 17, 18, 18), d);
      do_lock(2, pcx(0, 0, 0, 0), pcy(16, 17, 18, 19), d);
      check("gap_done_cycle", d, 24);
      check("gap_cleared", int'(lines_cleared), 2);
      check("gap_total", int'(lines_total), 4);
      check("gap_cell_19_0", int'(grid[19][0]), 2);
      check("gap_cell_19_3", int'(grid[19][3]), 5);
      check("gap_cell_19_1", int'(grid[19][1]), 0);
      check("gap_cell_18_0", int'(grid[18][0]), 2);
      check("gap_top_out", int'(top_out), 0);

      // Collision queries
      @(posedge clk); #1 q_cx = pcx(10, 0, 0, 0); q_cy = pcy(0, 0, 0, 0);
      @(negedge clk); check("q_x_out_of_range", int'(q_hit), 1);
      @(posedge clk); #1 q_cx = pcx(0, 1, 2, 3); q_cy = pcy(19, 0, 0, 0);
      @(negedge clk); check("q_occupied", int'(q_hit), 1);
      @(posedge clk); #1 q_cx = pcx(0, 1, 2, 3); q_cy = pcy(0, 0, 0, 0);
      @(negedge clk); check("q_empty", int'(q_hit), 0);

      // Overlap sets sticky top_out
      do_lock(6, pcx(0, 1, 2, 3), pcy(19, 19, 19, 19), d);
      check("overlap_top_out", int'(top_out), 1);
      do_lock(6, pcx(7, 8, 7, 8), pcy(10, 10, 11, 11), d);
      check("sticky_top_out", int'(top_out), 1);

      // Clear wins over a simultaneous lock
      wait_ready();
      @(posedge clk); #1;
      clear_board = 1'b1; lk.lock_valid = 1'b1; lk.lock_type = 3'd7;
      lk.lock_cx = pcx(0, 1, 2, 3); lk.lock_cy = pcy(5, 5, 5, 5);
      @(posedge clk); #1;
      clear_board = 1'b0; lk.lock_valid = 1'b0;
      @(negedge clk);
      check("clr_cell_19_0", int'(grid[19][0]), 0);
      check("clr_cell_5_0", int'(grid[5][0]), 0);
      check("clr_top_out", int'(top_out), 0);
      check("clr_ready", int'(lk.lock_ready), 1);
      no_done_window("clr_no_done");

      // Reset in the middle of SCAN aborts the lock
      wait_ready();
      @(posedge clk); #1;
      lk.lock_valid = 1'b1; lk.lock_type = 3'd7;
      lk.lock_cx = pcx(0, 1, 2, 3); lk.lock_cy = pcy(19, 19, 19, 19);
      @(posedge clk); #1 lk.lock_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_cell_19_0", int'(grid[19][0]), 0);
      check("rst_cell_19_1", int'(grid[19][1]), 0);
      check("rst_ready", int'(lk.lock_ready), 1);
      no_done_window("rst_no_done");

      // Random locks, queries and occasional clears
      q_rand_en = 1;
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 19) == 0) begin
            do_clear();
         end else begin
            if ($urandom_range(0, 1) == 1) begin
               x0 = $urandom_range(0, 6);
               y0 = $urandom_range(15, 19);
               cx = pcx(x0, x0 + 1, x0 + 2, x0 + 3);
               cy = pcy(y0, y0, y0, y0);
            end else begin
               for (int i = 0; i < 4; i++) begin
                  cx[4*i +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15))
                                                              : 4'($urandom_range(0, 9));
                  cy[5*i +: 5] = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(20, 31))
                                                              : 5'($urandom_range(13, 19));
               end
            end
            do_lock($urandom_range(1, 7), cx, cy, d);
         end
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      wait_ready();
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tetris_board.md
# tetris_board

Playfield state owner for the Tetris design. It holds the 20×10 grid of 3-bit cell codes that the colour mapper reads every frame. It accepts piece-lock commands from the game controller, writes the four cells of a landed piece, then scans for and removes full rows, shifting everything above them down. It also answers combinational collision queries for the falling piece.

## Interface
**Parameters**
- ROWS, 20, grid rows; row 0 is the top.
- COLS, 10, grid columns; column 0 is the left.

**Ports**
- Clk  in  1  system clock.
- Reset_n  in  1  synchronous reset, active-low.
- clear_board  in  1  single-cycle request to zero the whole grid.
- lock_valid  in  1  lock request.
- lock_ready  out  1  board can accept a lock.
- lock_type  in  3  cell code to write, 1..7 (0 = empty).
- lock_cx  in  16  four column coords; cell i is at [4i+3:4i].
- lock_cy  in  20  four row coords; cell i is at [5i+4:5i].
- q_cx  in  16  query column coords, same packing as lock_cx.
- q_cy  in  20  query row coords, same packing as lock_cy.
- q_hit  out  1  combinational query result: any query cell is out of range or occupied.
- grid  out  3  unpacked [ROWS][COLS]; registered cell codes.
- lock_done  out  1  one-cycle pulse when a lock has fully finished.
- lines_cleared  out  3  rows removed by the last lock, 0..4.
- lines_total  out  16  running count of cleared rows; saturates at 16'hFFFF.
- top_out  out  1  sticky error flag.

## Operation
- FSM states are IDLE, WRITE, SCAN and DONE.
- lock_ready = (state==IDLE) && !clear_board && Reset_n.
- **IDLE**
  - If clear_board is high: all cells go to 0 and top_out goes to 0 at this edge. State stays IDLE. Clear takes priority over a simultaneous lock_valid, and that lock is not accepted.
  - If lock_valid && lock_ready: capture lock_type, lock_cx and lock_cy; clear lines_cleared to 0; go to WRITE.
  - clear_board is ignored outside IDLE.
- **WRITE** (one cycle)
  - Write lock_type into each of the four captured cells.
  - A cell with x≥COLS or y≥ROWS is skipped and sets top_out.
  - A target cell that is already non-zero is overwritten and sets top_out.
  - Duplicate coordinates within one lock are allowed.
  - Next state is SCAN with row pointer r=ROWS-1.
- **SCAN** (one row evaluated per cycle)
  - Row r is full when all of its COLS cells are non-zero.
  - Full row: in one edge, row j ← row j-1 for j=r down to 1, and row 0 ← 0. r is unchanged so the shifted-in row is rechecked. lines_cleared is incremented, and lines_total is incremented with saturation.
  - Not full and r>0: r ← r-1.
  - Not full and r==0: go to DONE.
- **DONE** (one cycle)
  - lock_done=1; go to IDLE.
  - lines_cleared holds its value until the next lock is accepted.
- top_out is cleared only by reset or clear_board.
- q_hit is purely combinational from q_cx, q_cy and the current grid. It is valid in every state, but is only meaningful in IDLE.

## Timing
- Reset values: every grid cell 0, state IDLE, lock_done 0, lines_cleared 0, lines_total 0, top_out 0. lock_ready is 0 while Reset_n is low and 1 on the first cycle after release.
- Let E0 be the edge that accepts a lock.
  - WRITE is cycle 1 after E0.
  - SCAN occupies cycles 2..21+k, where k is the number of rows cleared (20 non-full checks plus k full checks).
  - lock_done is high in cycle 22+k.
  - lock_ready rises in cycle 23+k.
- grid changes only on the WRITE edge, on full-row SCAN edges, on the clear edge and on the reset edge. Readers may see intermediate shifts during SCAN.
- Reset asserted in any state takes effect at the next edge: the operation is aborted, all outputs go to their reset values, and no lock_done is produced.
- The maximum lines_cleared is 4. More than 4 is unreachable with valid tetrominoes, but the counter is 3 bits and must not wrap below 7.

## Test plan
- Reset then release → all 200 cells 0, lock_ready=1, q_hit=0 for query (0,0)(1,0)(2,0)(3,0), lines_total=0.
- Lock type 4 at (4,18)(5,18)(4,19)(5,19) → those cells =4, lock_done in cycle 22, lines_cleared=0, top_out=0.
- Prefill rows 18–19 in all columns except 0 via locks, then an I piece (type 1) at (0,16)(0,17)(0,18)(0,19) → lock_done in cycle 24, lines_cleared=2, lines_total=2. Old rows 16–17 land in rows 18–19 (column 0 =1 in both), and rows 0–1 are 0.
- Full rows 17 and 19 with row 18 partial → lines_cleared=2, old row 18 content is found in row 19, lock_done in cycle 24.
- Query at x=10 → q_hit=1. Query covering an occupied cell → 1. Query of all-empty in-range cells → 0.
- Lock overlapping an occupied cell → top_out=1 and stays 1 through later clean locks. clear_board together with lock_valid → grid zero, top_out 0, lock not accepted. Reset_n low during SCAN → next cycle grid zero and no lock_done.
